bios_portb_arbiter: RTL and testbench

- Shares the BIOS ROM read port B between two requesters: the CPU memory stage (r0) and the debug/UART loader reader (r1).
- Accepts at most one read per cycle over a valid/ready handshake and drives the ROM port.
- Routes the ROM's 1-cycle-latency data back to whichever requester issued the read.
- Fixed priority goes to r0. A starvation guard guarantees r1 a grant within STARVE_MAX r0 grants.

---
 rtl/bios_portb_arbiter_pkg.sv | 9 +
 rtl/bios_portb_arbiter_if.sv | 37 +++
 rtl/bios_portb_arbiter_starve_ctr.sv | 35 +++
 rtl/bios_portb_arbiter.sv | 98 +++++++++
 tb/tb_bios_portb_arbiter.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/bios_portb_arbiter_pkg.sv
// Shared constants for the BIOS ROM port-B arbiter: grant/tag encodings and default widths.
package bios_arb_pkg;
    localparam logic [1:0] GNT_NONE = 2'd0;
    localparam logic [1:0] GNT_R0   = 2'd1;
    localparam logic [1:0] GNT_R1   = 2'd2;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 32;
endpackage

// File: rtl/bios_portb_arbiter_if.sv
// Requester handshakes plus the ROM port-B wires, bundled for the arbiter (slave) and its environment (master).
interface bios_portb_arbiter_if
    import bios_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              r0_valid;
    logic [ADDR_W-1:0] r0_addr;
    logic              r0_ready;
    logic              r0_rvalid;
    logic [DATA_W-1:0] r0_rdata;

    logic              r1_valid;
    logic [ADDR_W-1:0] r1_addr;
    logic              r1_ready;
    logic              r1_rvalid;
    logic [DATA_W-1:0] r1_rdata;

    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_dout;

    modport master (
        output r0_valid, r0_addr, r1_valid, r1_addr, mem_dout,
        input  r0_ready, r0_rvalid, r0_rdata,
        input  r1_ready, r1_rvalid, r1_rdata,
        input  mem_en, mem_addr
    );

    modport slave (
        input  r0_valid, r0_addr, r1_valid, r1_addr, mem_dout,
        output r0_ready, r0_rvalid, r0_rdata,
        output r1_ready, r1_rvalid, r1_rdata,
        output mem_en, mem_addr
    );
endinterface

// File: rtl/bios_portb_arbiter_starve_ctr.sv
// Saturating count of r0 grants taken while r1 waits; force_r1 flags that r1 must win next.
module bios_arb_starve_ctr #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic r0_gnt,
    input  logic r1_gnt,
    input  logic r1_waiting,
    output logic force_r1
);
    localparam logic [3:0] MAX_CNT = 4'(STARVE_MAX);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (r1_gnt || !r1_waiting) begin
            cnt_d = 4'd0;
        end else if (r0_gnt && (cnt_q < MAX_CNT)) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign force_r1 = (cnt_q == MAX_CNT);
endmodule

// File: rtl/bios_portb_arbiter.sv
// Two-requester arbiter for BIOS ROM port B: r0 priority with a starvation guard for r1,
// one read per cycle, responses steered back by a registered tag (2-cycle total latency).
module bios_portb_arbiter
    import bios_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    bios_portb_arbiter_if.slave  bus
);
    logic [1:0]        grant;
    logic [1:0]        tag_q;
    logic [1:0]        tag_d;
    logic [ADDR_W-1:0] mem_addr;
    logic              force_r1;

    bios_arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk        (clk),
        .rst        (rst),
        .r0_gnt     (grant == GNT_R0),
        .r1_gnt     (grant == GNT_R1),
        .r1_waiting (bus.r1_valid),
        .force_r1   (force_r1)
    );

    // Grant is suppressed during reset so no ROM read or ready escapes.
    always_comb begin
        grant = GNT_NONE;
        if (!rst) begin
            if (force_r1 && bus.r1_valid) begin
                grant = GNT_R1;
            end else if (bus.r0_valid) begin
                grant = GNT_R0;
            end else if (bus.r1_valid) begin
                grant = GNT_R1;
            end
        end
    end

    always_comb begin
        mem_addr = '0;
        case (grant)
            GNT_R0:  mem_addr = bus.r0_addr;
            GNT_R1:  mem_addr = bus.r1_addr;
            default: mem_addr = '0;
        endcase
    end

    assign bus.r0_ready = (grant == GNT_R0);
    assign bus.r1_ready = (grant == GNT_R1);
    assign bus.mem_en   = (grant != GNT_NONE);
    assign bus.mem_addr = mem_addr;

    assign tag_d = grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q <= GNT_NONE;
        end else begin
            tag_q <= tag_d;
        end
    end

    // The tag lines up with ROM data one cycle after issue; capture both into the owner's response regs.
    for (genvar gi = 0; gi < 2; gi++) begin : g_resp
        localparam logic [1:0] MY_TAG = (gi == 0) ? GNT_R0 : GNT_R1;

        logic              rvalid_q;
        logic              rvalid_d;
        logic [DATA_W-1:0] rdata_q;
        logic [DATA_W-1:0] rdata_d;

        always_comb begin
            rvalid_d = (tag_q == MY_TAG);
            rdata_d  = rvalid_d ? bus.mem_dout : rdata_q;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                rvalid_q <= 1'b0;
                rdata_q  <= '0;
            end else begin
                rvalid_q <= rvalid_d;
                rdata_q  <= rdata_d;
            end
        end
    end

    assign bus.r0_rvalid = g_resp[0].rvalid_q;
    assign bus.r0_rdata  = g_resp[0].rdata_q;
    assign bus.r1_rvalid = g_resp[1].rvalid_q;
    assign bus.r1_rdata  = g_resp[1].rdata_q;
endmodule

// File: tb/tb_bios_portb_arbiter.sv
// Bench for bios_portb_arbiter: directed scenarios plus random traffic, all scored against a
// cycle-based reference model of the grant rules and a queue of expected responses per requester.
module tb_bios_portb_arbiter;
    localparam int STARVE_MAX = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bios_portb_arbiter_if #(.ADDR_W(12), .DATA_W(32)) bus ();

    bios_portb_arbiter #(
        .ADDR_W     (12),
        .DATA_W     (32),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [31:0] rom(input logic [11:0] a);
        return {20'h0, a} ^ 32'hA5A5_0000;
    endfunction

    // 1-cycle ROM: registered read on enable.
    always @(posedge clk) begin
        if (bus.mem_en) bus.mem_dout <= rom(bus.mem_addr);
    end

    typedef struct {
        int          due;
        logic [31:0] data;
        logic [11:0] addr;
    } resp_t;

    resp_t q0[$];
    resp_t q1[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int starve = 0;
    logic [31:0] exp_d0 = '0;
    logic [31:0] exp_d1 = '0;
    int rv0_cnt = 0;
    int rv1_cnt = 0;
    logic last_r0_ready = 1'b0;
    logic last_r1_ready = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    // Score one cycle against the rules, then advance the model.
    task automatic eval_cycle();
        int g;
        logic [11:0] ea;
        logic ev0, ev1;
        g = 0;
        if (!rst) begin
            if (starve == STARVE_MAX && bus.r1_valid) g = 2;
            else if (bus.r0_valid) g = 1;
            else if (bus.r1_valid) g = 2;
        end
        ea = (g == 1) ? bus.r0_addr : (g == 2) ? bus.r1_addr : 12'h000;

        chk("r0_ready", {31'b0, bus.r0_ready}, {31'b0, g == 1});
        chk("r1_ready", {31'b0, bus.r1_ready}, {31'b0, g == 2});
        chk("mem_en",   {31'b0, bus.mem_en},   {31'b0, g != 0});
        chk("mem_addr", {20'b0, bus.mem_addr}, {20'b0, ea});

        ev0 = (q0.size() > 0) && (q0[0].due == cyc);
        if (ev0) begin
            exp_d0 = q0[0].data;
            $display("cyc %0d r0 resp addr %h data %h", cyc, q0[0].addr, q0[0].data);
            void'(q0.pop_front());
        end
        ev1 = (q1.size() > 0) && (q1[0].due == cyc);
        if (ev1) begin
            exp_d1 = q1[0].data;
            $display("cyc %0d r1 resp addr %h data %h", cyc, q1[0].addr, q1[0].data);
            void'(q1.pop_front());
        end
        chk("r0_rvalid", {31'b0, bus.r0_rvalid}, {31'b0, ev0});
        chk("r1_rvalid", {31'b0, bus.r1_rvalid}, {31'b0, ev1});
        chk("r0_rdata", bus.r0_rdata, exp_d0);
        chk("r1_rdata", bus.r1_rdata, exp_d1);

        if (bus.r0_rvalid) rv0_cnt++;
        if (bus.r1_rvalid) rv1_cnt++;
        last_r0_ready = bus.r0_ready;
        last_r1_ready = bus.r1_ready;

        if (g == 1) q0.push_back('{cyc + 2, rom(bus.r0_addr), bus.r0_addr});
        if (g == 2) q1.push_back('{cyc + 2, rom(bus.r1_addr), bus.r1_addr});

        if (rst) begin
            q0.delete();
            q1.delete();
            exp_d0 = '0;
            exp_d1 = '0;
            starve = 0;
        end else if (g == 2 || !bus.r1_valid) begin
            starve = 0;
        end else if (g == 1 && starve < STARVE_MAX) begin
            starve++;
        end
    endtask

    task automatic step(input logic v0, input logic [11:0] a0,
                        input logic v1, input logic [11:0] a1, input logic r);
        bus.r0_valid = v0;
        bus.r0_addr  = a0;
        bus.r1_valid = v1;
        bus.r1_addr  = a1;
        rst          = r;
        @(negedge clk);
        eval_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 12'h0, 1'b0, 12'h0, 1'b0);
    endtask

    initial begin
        int base0, base1, ia;
        logic [9:0] order;
        logic v0, v1, rr;
        logic [11:0] a0, a1;

        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) step(1'b0, 12'h0, 1'b0, 12'h0, 1'b1);
        idle(2);

        // Single r0 read
        base0 = rv0_cnt; base1 = rv1_cnt;
        step(1'b1, 12'h010, 1'b0, 12'h0, 1'b0);
        idle(3);
        chk("single_rdata", bus.r0_rdata, 32'hA5A5_0010);
        chk("single_pulses", rv0_cnt - base0, 1);
        chk("single_r1_quiet", rv1_cnt - base1, 0);

        // Simultaneous requests
        step(1'b1, 12'h001, 1'b1, 12'h002, 1'b0);
        chk("simul_first_r0", {31'b0, last_r0_ready}, 1);
        step(1'b0, 12'h000, 1'b1, 12'h002, 1'b0);
        chk("simul_second_r1", {31'b0, last_r1_ready}, 1);
        idle(3);
        chk("simul_r0_rdata", bus.r0_rdata, 32'hA5A5_0001);
        chk("simul_r1_rdata", bus.r1_rdata, 32'hA5A5_0002);

        // Starvation guard
        ia = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 12'(ia), 1'b1, 12'hFFF, 1'b0);
            order[i] = last_r1_ready;
            if (last_r0_ready) ia++;
        end
        idle(3);
        chk("starve_order", {22'b0, order}, {22'b0, 10'b10_0001_0000});
        chk("starve_r1_rdata", bus.r1_rdata, 32'hA5A5_0FFF);

        // Streaming
        base1 = rv1_cnt;
        for (int i = 0; i < 256; i++) step(1'b0, 12'h0, 1'b1, 12'(i), 1'b0);
        idle(2);
        chk("stream_pulses", rv1_cnt - base1, 256);
        chk("stream_last", bus.r1_rdata, 32'hA5A5_00FF);

        // Reset right after an accept
        base0 = rv0_cnt;
        step(1'b1, 12'h020, 1'b0, 12'h0, 1'b0);
        step(1'b0, 12'h000, 1'b0, 12'h0, 1'b1);
        idle(3);
        chk("rst_no_pulse", rv0_cnt - base0, 0);
        chk("rst_rdata_zero", bus.r0_rdata, 32'h0);
        step(1'b1, 12'h021, 1'b0, 12'h0, 1'b0);
        idle(3);
        chk("rst_after_rdata", bus.r0_rdata, 32'hA5A5_0021);

        // Early withdrawal of r1, then a fresh starvation window must start from zero
        base1 = rv1_cnt;
        step(1'b1, 12'h005, 1'b1, 12'h007, 1'b0);
        idle(3);
        chk("withdraw_no_pulse", rv1_cnt - base1, 0);
        ia = -1;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 12'(i), 1'b1, 12'h0AB, 1'b0);
            if (last_r1_ready && ia < 0) ia = i;
        end
        chk("withdraw_ctr_cleared", ia, 4);
        idle(3);

        // Random traffic, honouring hold-until-ready except for occasional r1 withdrawal
        v0 = 1'b0; v1 = 1'b0; a0 = '0; a1 = '0;
        for (int k = 0; k < 500; k++) begin
            if (!v0 || last_r0_ready) begin
                v0 = ($urandom_range(0, 99) < 60);
                a0 = 12'($urandom);
            end
            if (!v1 || last_r1_ready) begin
                v1 = ($urandom_range(0, 99) < 50);
                a1 = 12'($urandom);
            end else if ($urandom_range(0, 99) < 10) begin
                v1 = 1'b0;
            end
            rr = ($urandom_range(0, 149) == 0);
            step(v0, a0, v1, a1, rr);
            if (rr) begin
                last_r0_ready = 1'b0;
                last_r1_ready = 1'b0;
            end
        end
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
